// File: rtl/ps2_keyboard.sv
// PS/2 host-side keyboard receiver. Deserialises 11-bit keyboard frames,
// drops break (release) sequences, and queues make scan codes in a small FIFO
// that the memory subsystem pops one entry per clean_key_buffer rising edge.
module ps2_keyboard #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic        clean_key_buffer,
    output logic [7:0]  pressed_key,
    output logic        keyboard_valid,
    output logic        frame_error,
    output logic        overflow,
    output logic [31:0] debug
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DATA   = 4'd1,
        ST_PARITY = 4'd2,
        ST_STOP   = 4'd3
    } state_t;

    // Synchronisers and edge detection
    logic ps2_clk_meta, ps2_clk_sync, ps2_clk_prev;
    logic ps2_data_meta, ps2_data_sync;
    logic fall_edge;

    // Frame receiver
    state_t          state, state_next;
    logic [3:0]      bit_cnt, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_bit, parity_next;
    logic [TO_W-1:0] timeout_cnt, timeout_next;
    logic            frame_error_next;
    logic            code_valid, code_valid_next;
    logic [7:0]      code_reg, code_next;

    // Decode
    logic       break_pending, break_pending_next;
    logic [7:0] last_code, last_code_next;
    logic       push_req;

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             clean_prev;
    logic             pop_req, pop_ok, push_ok, push_drop;

    // Two-flop synchronisers on both PS/2 pins plus a delayed clock copy for edge detect; idle-high after reset
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ps2_clk_meta  <= 1'b1;
            ps2_clk_sync  <= 1'b1;
            ps2_clk_prev  <= 1'b1;
            ps2_data_meta <= 1'b1;
            ps2_data_sync <= 1'b1;
        end else begin
            ps2_clk_meta  <= PS2_CLK;
            ps2_clk_sync  <= ps2_clk_meta;
            ps2_clk_prev  <= ps2_clk_sync;
            ps2_data_meta <= PS2_DATA;
            ps2_data_sync <= ps2_data_meta;
        end
    end

    assign fall_edge = ps2_clk_prev & ~ps2_clk_sync;

    // Receiver state register and frame datapath
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            shift_reg   <= 8'h00;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
            frame_error <= 1'b0;
            code_valid  <= 1'b0;
            code_reg    <= 8'h00;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_bit  <= parity_next;
            timeout_cnt <= timeout_next;
            frame_error <= frame_error_next;
            code_valid  <= code_valid_next;
            code_reg    <= code_next;
        end
    end

    // Receiver next state: advance on each keyboard clock falling edge, otherwise run the stall timeout
    always_comb begin
        state_next       = state;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift_reg;
        parity_next      = parity_bit;
        timeout_next     = timeout_cnt;
        frame_error_next = 1'b0;
        code_valid_next  = 1'b0;
        code_next        = code_reg;

        if (fall_edge) begin
            timeout_next = '0;
            case (state)
                ST_IDLE: begin
                    if (!ps2_data_sync) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 4'd0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {ps2_data_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_next = ps2_data_sync;
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (ps2_data_sync && (^{shift_reg, parity_bit})) begin
                        code_valid_next = 1'b1;
                        code_next       = shift_reg;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end else if (state == ST_IDLE) begin
            timeout_next = '0;
        end else if (timeout_cnt == TO_LAST) begin
            state_next       = ST_IDLE;
            timeout_next     = '0;
            bit_cnt_next     = 4'd0;
            shift_next       = 8'h00;
            frame_error_next = 1'b1;
        end else begin
            timeout_next = timeout_cnt + 1'b1;
        end
    end

    // Decode register: break prefix tracking and the last code queued
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            break_pending <= 1'b0;
            last_code     <= 8'h00;
        end else begin
            break_pending <= break_pending_next;
            last_code     <= last_code_next;
        end
    end

    // Decode a completed code: F0 arms break, E0 is ignored, the code after F0 is swallowed, the rest are pushed
    always_comb begin
        break_pending_next = break_pending;
        last_code_next     = last_code;
        push_req           = 1'b0;

        if (code_valid) begin
            if (code_reg == 8'hF0) begin
                break_pending_next = 1'b1;
            end else if (code_reg == 8'hE0) begin
                break_pending_next = break_pending;
            end else if (break_pending) begin
                break_pending_next = 1'b0;
            end else begin
                push_req       = 1'b1;
                last_code_next = code_reg;
            end
        end
    end

    // Push/pop qualification; a pop on a full FIFO frees the slot a same-cycle push needs
    always_comb begin
        pop_req   = clean_key_buffer & ~clean_prev;
        pop_ok    = pop_req && (fifo_count != '0);
        push_ok   = push_req && ((fifo_count != CNT_FULL) || pop_ok);
        push_drop = push_req && !push_ok;
    end

    // FIFO storage, pointers, occupancy, pop edge detect and sticky overflow
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 8'h00;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            clean_prev <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            clean_prev <= clean_key_buffer;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= code_reg;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign keyboard_valid = (fifo_count != '0);
    assign pressed_key    = keyboard_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign debug          = {8'(fifo_count), 4'(state), bit_cnt, last_code, 7'b0, break_pending};

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed testbench for ps2_keyboard: drives PS/2 frames bit by bit and checks
// the key FIFO, break filtering, error pulses, timeout and pop behaviour.
module tb_ps2_keyboard;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        PS2_CLK;
    logic        PS2_DATA;
    logic        clean_key_buffer;
    logic [7:0]  pressed_key;
    logic        keyboard_valid;
    logic        frame_error;
    logic        overflow;
    logic [31:0] debug;

    int         total = 0;
    int         bad = 0;
    int         err_pulses = 0;
    int         err_base;
    int         valid_lat;
    int         snap_count;
    logic [7:0] snap_head;

    ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK              (CLK),
        .resetn           (resetn),
        .PS2_CLK          (PS2_CLK),
        .PS2_DATA         (PS2_DATA),
        .clean_key_buffer (clean_key_buffer),
        .pressed_key      (pressed_key),
        .keyboard_valid   (keyboard_valid),
        .frame_error      (frame_error),
        .overflow         (overflow),
        .debug            (debug)
    );

    // 10 ns system clock
    always #5 CLK = ~CLK;

    // Count frame_error pulses; each pulse is one cycle wide so it is seen once
    always @(negedge CLK) begin
        if (frame_error === 1'b1) err_pulses++;
    end

    // Safety net so a stuck run still ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One PS/2 bit: data set while the keyboard clock is high, then a 15-cycle low pulse
    task automatic ps2Bit(input logic b);
        PS2_DATA = b;
        waitCycles(8);
        PS2_CLK = 1'b0;
        waitCycles(15);
        PS2_CLK = 1'b1;
        waitCycles(7);
    endtask

    // Full frame; pop_at>0 raises clean_key_buffer that many cycles after the stop falling edge
    task automatic applyStimulus(input logic [7:0] code, input logic flip, input int pop_at);
        logic par;
        par        = (~^code) ^ flip;
        valid_lat  = 99;
        snap_count = -1;
        snap_head  = 8'h00;
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(code[i]);
        ps2Bit(par);
        PS2_DATA = 1'b1;
        waitCycles(8);
        PS2_CLK = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge CLK);
            if (valid_lat == 99 && keyboard_valid === 1'b1) valid_lat = i;
            if (pop_at > 0 && i == pop_at) clean_key_buffer = 1'b1;
            if (pop_at > 0 && i == pop_at + 3) clean_key_buffer = 1'b0;
            if (pop_at > 0 && i == pop_at + 1) begin
                snap_count = int'(debug[31:24]);
                snap_head  = pressed_key;
            end
        end
        clean_key_buffer = 1'b0;
        PS2_CLK = 1'b1;
        waitCycles(7);
    endtask

    // Start bit plus nbits-1 data bits, then the keyboard clock stays high
    task automatic partialFrame(input logic [7:0] code, input int nbits);
        ps2Bit(1'b0);
        for (int i = 0; i < nbits - 1; i++) ps2Bit(code[i]);
    endtask

    // Pop request held high for three cycles; must remove exactly one entry
    task automatic popKey();
        clean_key_buffer = 1'b1;
        waitCycles(3);
        clean_key_buffer = 1'b0;
        waitCycles(2);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        waitCycles(3);
        resetn = 1'b1;
        waitCycles(3);
    endtask

    // Directed sequence
    initial begin
        resetn           = 1'b0;
        PS2_CLK          = 1'b1;
        PS2_DATA         = 1'b1;
        clean_key_buffer = 1'b0;
        waitCycles(4);
        checkOutput("rst_valid", 32'(keyboard_valid), 0);
        checkOutput("rst_key", 32'(pressed_key), 0);
        checkOutput("rst_ferr", 32'(frame_error), 0);
        checkOutput("rst_ovf", 32'(overflow), 0);
        checkOutput("rst_debug", debug, 0);
        resetn = 1'b1;
        waitCycles(3);

        // Single make code and latency
        applyStimulus(8'h1C, 1'b0, 0);
        checkOutput("lat_1c", 32'(valid_lat <= 5), 1);
        checkOutput("valid_1c", 32'(keyboard_valid), 1);
        checkOutput("key_1c", 32'(pressed_key), 32'h1C);
        checkOutput("last_code_1c", 32'(debug[15:8]), 32'h1C);
        popKey();
        checkOutput("pop_valid", 32'(keyboard_valid), 0);
        checkOutput("pop_key", 32'(pressed_key), 0);
        checkOutput("pop_count", 32'(debug[31:24]), 0);

        // E0 prefix is ignored
        applyStimulus(8'hE0, 1'b0, 0);
        checkOutput("e0_count", 32'(debug[31:24]), 0);
        checkOutput("e0_bp", 32'(debug[0]), 0);

        // Break sequence F0 1C is swallowed, then 32 is queued
        applyStimulus(8'hF0, 1'b0, 0);
        checkOutput("f0_bp", 32'(debug[0]), 1);
        checkOutput("f0_count", 32'(debug[31:24]), 0);
        applyStimulus(8'h1C, 1'b0, 0);
        applyStimulus(8'h32, 1'b0, 0);
        checkOutput("brk_count", 32'(debug[31:24]), 1);
        checkOutput("brk_key", 32'(pressed_key), 32'h32);
        checkOutput("brk_bp", 32'(debug[0]), 0);
        popKey();

        // Parity error
        err_base = err_pulses;
        applyStimulus(8'h1C, 1'b1, 0);
        checkOutput("par_err", 32'(err_pulses - err_base), 1);
        checkOutput("par_valid", 32'(keyboard_valid), 0);
        applyStimulus(8'h1C, 1'b0, 0);
        checkOutput("par_next_key", 32'(pressed_key), 32'h1C);
        checkOutput("par_next_cnt", 32'(debug[31:24]), 1);
        checkOutput("par_no_err", 32'(err_pulses - err_base), 1);
        popKey();

        // Timeout on a stalled partial frame
        err_base = err_pulses;
        partialFrame(8'h5A, 5);
        checkOutput("to_mid_state", 32'(debug[23:20]), 1);
        waitCycles(TMO + 10);
        checkOutput("to_err", 32'(err_pulses - err_base), 1);
        checkOutput("to_state", 32'(debug[23:20]), 0);
        applyStimulus(8'h1C, 1'b0, 0);
        checkOutput("to_next_key", 32'(pressed_key), 32'h1C);
        checkOutput("to_next_cnt", 32'(debug[31:24]), 1);
        popKey();

        // Overflow with six codes into a four-entry FIFO
        applyStimulus(8'h15, 1'b0, 0);
        applyStimulus(8'h1D, 1'b0, 0);
        applyStimulus(8'h24, 1'b0, 0);
        applyStimulus(8'h2D, 1'b0, 0);
        checkOutput("full_ovf0", 32'(overflow), 0);
        applyStimulus(8'h2C, 1'b0, 0);
        applyStimulus(8'h35, 1'b0, 0);
        checkOutput("ovf_count", 32'(debug[31:24]), 4);
        checkOutput("ovf_flag", 32'(overflow), 1);
        checkOutput("ovf_key0", 32'(pressed_key), 32'h15);
        popKey();
        checkOutput("ovf_key1", 32'(pressed_key), 32'h1D);
        popKey();
        checkOutput("ovf_key2", 32'(pressed_key), 32'h24);
        popKey();
        checkOutput("ovf_key3", 32'(pressed_key), 32'h2D);
        popKey();
        checkOutput("ovf_empty", 32'(keyboard_valid), 0);
        checkOutput("ovf_sticky", 32'(overflow), 1);

        // Reset in the middle of a frame
        partialFrame(8'hAA, 3);
        doReset();
        checkOutput("mid_rst_ovf", 32'(overflow), 0);
        checkOutput("mid_rst_state", 32'(debug[23:20]), 0);
        applyStimulus(8'h1C, 1'b0, 0);
        checkOutput("mid_rst_key", 32'(pressed_key), 32'h1C);
        popKey();

        // Simultaneous push and pop with one entry
        applyStimulus(8'h2C, 1'b0, 0);
        applyStimulus(8'h35, 1'b0, 3);
        checkOutput("sim1_snap_cnt", 32'(snap_count), 1);
        checkOutput("sim1_snap_key", 32'(snap_head), 32'h35);
        checkOutput("sim1_key", 32'(pressed_key), 32'h35);
        popKey();
        checkOutput("sim1_empty", 32'(keyboard_valid), 0);

        // Simultaneous push and pop with the FIFO full
        applyStimulus(8'h15, 1'b0, 0);
        applyStimulus(8'h1D, 1'b0, 0);
        applyStimulus(8'h24, 1'b0, 0);
        applyStimulus(8'h2D, 1'b0, 0);
        applyStimulus(8'h43, 1'b0, 3);
        checkOutput("simf_snap_cnt", 32'(snap_count), 4);
        checkOutput("simf_snap_key", 32'(snap_head), 32'h1D);
        checkOutput("simf_ovf", 32'(overflow), 0);
        popKey();
        checkOutput("simf_key1", 32'(pressed_key), 32'h24);
        popKey();
        checkOutput("simf_key2", 32'(pressed_key), 32'h2D);
        popKey();
        checkOutput("simf_key3", 32'(pressed_key), 32'h43);
        popKey();
        checkOutput("simf_empty", 32'(keyboard_valid), 0);
        checkOutput("simf_ferr", 32'(err_pulses - err_base), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 host-side receiver and key buffer. It deserialises keyboard frames, drops break (release) sequences, and queues make scan codes in a small FIFO.
- It is the upstream source for the memory subsystem keyboard path. It drives pressed_key and keyboard_valid, and consumes clean_key_buffer as the pop request when the CPU reads address 0xFFFFFFFF.

Parameters:
FIFO_DEPTH, 4, key FIFO entries; power of two, 2..16
TIMEOUT_CYCLES, 24000, CLK cycles without a PS2_CLK falling edge before a partial frame is discarded (2 ms at 12 MHz)

Ports:
CLK  input  1  CPU clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
PS2_CLK  input  1  keyboard clock, asynchronous, open-drain (pulled high)
PS2_DATA  input  1  keyboard data, asynchronous
clean_key_buffer  input  1  pop request from memory subsystem; level, may stay high several cycles
pressed_key  output  8  FIFO head scan code; 8'h00 when empty
keyboard_valid  output  1  FIFO non-empty
frame_error  output  1  one-cycle pulse on parity, start, stop or timeout error
overflow  output  1  sticky; set when a code is dropped on full FIFO; cleared only by reset
debug  output  32  {fifo_count[7:0], state[3:0], bit_cnt[3:0], last_code[7:0], 7'b0, break_pending}

Behaviour:
- Reset (async, resetn=0):
  - FIFO empty, pointers 0; state IDLE.
  - keyboard_valid=0, pressed_key=0, frame_error=0, overflow=0.
  - break_pending=0, timeout counter 0.
  - Synchronisers load 1.
- Input synchronisation:
  - PS2_CLK and PS2_DATA each pass through 2 FFs.
  - A falling edge = synced clk previous 1, current 0.
  - PS2_DATA is sampled from its synced copy in the cycle the edge is detected (3 CLK cycles after the pin edge).
- Frame format: start 0, 8 data bits LSB first, odd parity, stop 1.
- FSM, advancing on each detected falling edge:
  - IDLE: if data=0, go to DATA with bit_cnt=0. If data=1, stay in IDLE with no error (glitch).
  - DATA: shift data in at bit 7 (shift right); bit_cnt++. After the 8th bit go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP: check stop=1 and that XOR of the 8 data bits and parity equals 1.
    - Pass: the frame is valid and the code goes to decode. Return to IDLE.
    - Fail: frame_error pulse, code discarded, return to IDLE.
- Timeout:
  - The counter clears on every falling edge and in IDLE; it increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 outside IDLE: go to IDLE, pulse frame_error, discard partial bits. break_pending is unchanged.
- Decode of a valid code, acted on in the cycle after the STOP edge:
  - 8'hF0: set break_pending; no push.
  - 8'hE0: ignored; no push; break_pending unchanged.
  - Other code with break_pending=1: clear break_pending; no push.
  - Other code with break_pending=0: push the code and update last_code.
- Pop:
  - Pop happens on the rising edge of clean_key_buffer (registered previous value 0, current 1), so exactly one pop per request however long it is held.
  - Pop when empty has no effect.
- FIFO:
  - pressed_key and keyboard_valid are driven from registered head and count, with no combinational path from clean_key_buffer.
  - After a push into an empty FIFO: keyboard_valid=1 and pressed_key=code on the next cycle.
  - Push while full: code dropped, overflow set, FIFO contents unchanged.
  - Simultaneous push and pop:
    - Non-empty: both take effect, count unchanged, and the new head appears the next cycle.
    - Empty: the pop is ignored and the push takes effect.
    - Full: the pop frees a slot, so the push is accepted and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count ranges 0..FIFO_DEPTH.
- Reset mid-frame: the frame is abandoned. The next falling edge is interpreted from IDLE.

Test Plan:
- Reset, then one frame carrying 8'h1C with parity 0 (three 1s, so the parity bit is 0) -> within 5 CLK cycles of the stop edge, keyboard_valid=1 and pressed_key=8'h1C. Then hold clean_key_buffer high for 3 cycles -> exactly one pop, keyboard_valid=0, pressed_key=8'h00.
- Frames F0, 1C, then 32 -> only 8'h32 is queued; fifo_count=1; break_pending=0 at the end.
- Frame 1C with the parity bit flipped -> one frame_error pulse, FIFO empty. A following valid frame 1C is accepted.
- Send 6 valid make codes 15, 1D, 24, 2D, 2C, 35 with FIFO_DEPTH=4 -> FIFO holds 15, 1D, 24, 2D; overflow=1. Four pops return them in order.
- Stop PS2_CLK after 5 bits for TIMEOUT_CYCLES+10 cycles -> frame_error pulses once, state returns to IDLE. A following full frame 8'h1C is received correctly.
- With the FIFO holding 1 entry, a clean_key_buffer rising edge lands in the same cycle as a decode push -> count stays 1 and pressed_key becomes the new code the next cycle. Repeat with the FIFO full -> push accepted, overflow stays 0.
